// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared constants for the register-file write-back path: widths, register count
// and the fixed requester slot assignment.
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;
    localparam int NUM_REGS   = 32;

    localparam int REQ_ALU = 0;
    localparam int REQ_LSU = 1;
    localparam int REQ_MUL = 2;

endpackage

// File: rtl/regfile_wb_scheduler_if.sv
// Write-back request bus between the execution units (master) and the
// write-back scheduler (slave); one valid/ready lane per requester.
interface regfile_wb_scheduler_if #(
    parameter int NUM_REQ = 3
);

    logic [NUM_REQ-1:0]                        req_valid;
    logic [NUM_REQ-1:0]                        req_ready;
    logic [NUM_REQ*regfile_pkg::REG_ADDR_W-1:0] req_rd_addr;
    logic [NUM_REQ*regfile_pkg::XLEN-1:0]       req_rd_data;

    modport master (
        output req_valid,
        output req_rd_addr,
        output req_rd_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_rd_addr,
        input  req_rd_data,
        output req_ready
    );

endinterface

// File: rtl/regfile_wb_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first requesting index at or after ptr,
// wrapping modulo N, as a one-hot vector plus its index.
module rr_arbiter #(
    parameter int N = 3,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid
);

    always_comb begin
        int idx;
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        idx         = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!grant_valid && req[idx]) begin
                grant[idx]  = 1'b1;
                grant_idx   = IDX_W'(idx);
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Shares the register file's single write port among NUM_REQ producers and keeps
// a per-register pending-write scoreboard for RAW hazard detection at issue.
module regfile_wb_scheduler
    import regfile_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int CNT_W   = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    regfile_wb_scheduler_if.slave  req_bus,
    output logic                   RegWEn,
    output logic [REG_ADDR_W-1:0]  rd_addr,
    output logic [XLEN-1:0]        rd_data,
    input  logic                   iss_valid,
    input  logic [REG_ADDR_W-1:0]  iss_rd_addr,
    output logic                   iss_ready,
    input  logic [REG_ADDR_W-1:0]  rs1_addr,
    input  logic [REG_ADDR_W-1:0]  rs2_addr,
    output logic                   hazard_rs1,
    output logic                   hazard_rs2
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [IDX_W-1:0]      rr_ptr;
    logic [IDX_W-1:0]      grant_idx;
    logic [NUM_REQ-1:0]    grant;
    logic [NUM_REQ-1:0]    req_masked;
    logic                  grant_valid;
    logic [REG_ADDR_W-1:0] sel_addr;
    logic [XLEN-1:0]       sel_data;
    logic [CNT_W-1:0]      cnt [NUM_REGS];
    logic [NUM_REGS-1:0]   inc_vec;
    logic [NUM_REGS-1:0]   dec_vec;

    // Masking with rst_n keeps every ready low for as long as reset is held.
    assign req_masked = req_bus.req_valid & {NUM_REQ{rst_n}};

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req         (req_masked),
        .ptr         (rr_ptr),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    assign req_bus.req_ready = grant;
    assign sel_addr = req_bus.req_rd_addr[int'(grant_idx)*REG_ADDR_W +: REG_ADDR_W];
    assign sel_data = req_bus.req_rd_data[int'(grant_idx)*XLEN +: XLEN];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RegWEn  <= 1'b0;
            rd_addr <= '0;
            rd_data <= '0;
            rr_ptr  <= '0;
        end else begin
            RegWEn <= grant_valid && (sel_addr != '0);
            if (grant_valid) begin
                rd_addr <= sel_addr;
                rd_data <= sel_data;
                rr_ptr  <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            end
        end
    end

    assign iss_ready  = (cnt[iss_rd_addr] != CNT_MAX);
    assign hazard_rs1 = (rs1_addr != '0) && (cnt[rs1_addr] != '0);
    assign hazard_rs2 = (rs2_addr != '0) && (cnt[rs2_addr] != '0);

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        if (iss_valid && iss_ready && (iss_rd_addr != '0)) inc_vec[iss_rd_addr] = 1'b1;
        if (RegWEn && (rd_addr != '0)) dec_vec[rd_addr] = 1'b1;
    end

    // The commit edge retires the entry, so a read in the next cycle is hazard-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (inc_vec[r] && !dec_vec[r]) begin
                    cnt[r] <= cnt[r] + 1'b1;
                end else if (dec_vec[r] && !inc_vec[r] && (cnt[r] != '0)) begin
                    cnt[r] <= cnt[r] - 1'b1;
                end
            end
        end
    end

    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(RegWEn && (rd_addr != '0) && (cnt[rd_addr] == '0)));

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Randomized plus directed bench for regfile_wb_scheduler, checked against a
// behavioural scoreboard/arbitration model kept in the bench.
module tb_regfile_wb_scheduler;
    import regfile_pkg::*;

    localparam int NR      = 3;
    localparam int CNT_MAX = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        RegWEn;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        iss_valid;
    logic [4:0]  iss_rd_addr;
    logic        iss_ready;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        hazard_rs1;
    logic        hazard_rs2;

    regfile_wb_scheduler_if #(.NUM_REQ(NR)) bus ();

    regfile_wb_scheduler #(.NUM_REQ(NR), .CNT_W(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_bus     (bus),
        .RegWEn      (RegWEn),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .iss_valid   (iss_valid),
        .iss_rd_addr (iss_rd_addr),
        .iss_ready   (iss_ready),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .hazard_rs1  (hazard_rs1),
        .hazard_rs2  (hazard_rs2)
    );

    always #5 clk = ~clk;

    int checks_total  = 0;
    int checks_passed = 0;

    logic        drv_valid [NR];
    logic [4:0]  drv_addr  [NR];
    logic [31:0] drv_data  [NR];
    logic        drv_iss_valid;
    logic [4:0]  drv_iss_rd;
    logic [4:0]  drv_rs1;
    logic [4:0]  drv_rs2;

    // Reference state: pending-write count per register, next requester in turn,
    // the write presented to the register file, and issued-but-unrequested writes.
    int          m_cnt [32];
    int          owed  [32];
    int          m_ptr;
    logic        m_wen;
    logic [4:0]  m_addr;
    logic [31:0] m_data;

    logic [NR-1:0] last_ready;
    logic          last_iss_ready;
    logic          last_haz1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks_total++;
        if (observed === expected) checks_passed++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    endtask

    function automatic int modelGrant();
        for (int i = m_ptr; i < NR; i++) if (drv_valid[i]) return i;
        for (int i = 0; i < m_ptr; i++) if (drv_valid[i]) return i;
        return -1;
    endfunction

    task automatic modelReset();
        for (int r = 0; r < 32; r++) begin
            m_cnt[r] = 0;
            owed[r]  = 0;
        end
        m_ptr  = 0;
        m_wen  = 1'b0;
        m_addr = '0;
        m_data = '0;
        for (int i = 0; i < NR; i++) drv_valid[i] = 1'b0;
        drv_iss_valid = 1'b0;
    endtask

    task automatic quietInputs();
        bus.req_valid = '0;
        iss_valid     = 1'b0;
    endtask

    task automatic startReq(input int i, input logic [4:0] a, input logic [31:0] d);
        drv_valid[i] = 1'b1;
        drv_addr[i]  = a;
        drv_data[i]  = d;
        if (a != 0) owed[a]--;
    endtask

    // One clock cycle: drive at negedge, check combinational outputs, then check
    // the registered outputs just after the posedge and advance the model.
    task automatic applyStimulus();
        int            g;
        logic [NR-1:0] exp_ready;
        logic          exp_iss_ready;
        @(negedge clk);
        for (int i = 0; i < NR; i++) begin
            bus.req_valid[i]          = drv_valid[i];
            bus.req_rd_addr[i*5 +: 5]  = drv_addr[i];
            bus.req_rd_data[i*32 +: 32] = drv_data[i];
        end
        iss_valid   = drv_iss_valid;
        iss_rd_addr = drv_iss_rd;
        rs1_addr    = drv_rs1;
        rs2_addr    = drv_rs2;
        #1;
        g = modelGrant();
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        exp_iss_ready = (m_cnt[drv_iss_rd] < CNT_MAX);
        checkOutput("req_ready", 32'(bus.req_ready), 32'(exp_ready));
        checkOutput("iss_ready", 32'(iss_ready), 32'(exp_iss_ready));
        checkOutput("hazard_rs1", 32'(hazard_rs1), 32'(drv_rs1 != 0 && m_cnt[drv_rs1] != 0));
        checkOutput("hazard_rs2", 32'(hazard_rs2), 32'(drv_rs2 != 0 && m_cnt[drv_rs2] != 0));
        last_ready     = bus.req_ready;
        last_iss_ready = iss_ready;
        last_haz1      = hazard_rs1;
        @(posedge clk);
        #1;
        if (m_wen && m_cnt[m_addr] > 0) m_cnt[m_addr]--;
        if (drv_iss_valid && drv_iss_rd != 0 && exp_iss_ready) begin
            m_cnt[drv_iss_rd]++;
            owed[drv_iss_rd]++;
        end
        if (g >= 0) begin
            m_wen        = (drv_addr[g] != 0);
            m_addr       = drv_addr[g];
            m_data       = drv_data[g];
            m_ptr        = (g + 1) % NR;
            drv_valid[g] = 1'b0;
        end else begin
            m_wen = 1'b0;
        end
        checkOutput("RegWEn", 32'(RegWEn), 32'(m_wen));
        if (m_wen) begin
            checkOutput("rd_addr", 32'(rd_addr), 32'(m_addr));
            checkOutput("rd_data", rd_data, m_data);
        end
        drv_iss_valid = 1'b0;
    endtask

    task automatic issueOnly(input logic [4:0] rd);
        drv_iss_valid = 1'b1;
        drv_iss_rd    = rd;
        applyStimulus();
    endtask

    function automatic int pickOwed();
        int start;
        int r;
        start = $urandom_range(0, 31);
        for (int k = 0; k < 32; k++) begin
            r = (start + k) % 32;
            if (r != 0 && owed[r] > 0) return r;
        end
        return -1;
    endfunction

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int r;
        rst_n           = 1'b0;
        bus.req_valid   = '1;
        bus.req_rd_addr = '0;
        bus.req_rd_data = '0;
        iss_valid       = 1'b0;
        iss_rd_addr     = '0;
        rs1_addr        = 5'd10;
        rs2_addr        = 5'd3;
        drv_rs1         = '0;
        drv_rs2         = '0;
        drv_iss_rd      = '0;
        for (int i = 0; i < NR; i++) begin
            drv_addr[i] = '0;
            drv_data[i] = '0;
        end
        modelReset();

        // Reset held with every requester valid.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset req_ready", 32'(bus.req_ready), 32'd0);
        checkOutput("reset RegWEn", 32'(RegWEn), 32'd0);
        checkOutput("reset rd_addr", 32'(rd_addr), 32'd0);
        checkOutput("reset rd_data", rd_data, 32'd0);
        checkOutput("reset hazard_rs1", 32'(hazard_rs1), 32'd0);
        checkOutput("reset hazard_rs2", 32'(hazard_rs2), 32'd0);
        quietInputs();
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NR; i++) startReq(i, 5'd0, $urandom);
        applyStimulus();
        checkOutput("first grant", 32'(last_ready), 32'b001);
        repeat (2) applyStimulus();

        // Round-robin with all three requesters busy; six writes to 5/6/7.
        for (int k = 0; k < 2; k++) begin
            issueOnly(5'd5);
            issueOnly(5'd6);
            issueOnly(5'd7);
        end
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < NR; i++)
                if (!drv_valid[i] && k <= 3) startReq(i, 5'(5 + i), $urandom);
            applyStimulus();
            checkOutput($sformatf("rr order %0d", k), 32'(last_ready), 32'(1 << (k % 3)));
        end
        applyStimulus();

        // Two pending writes to x10; hazard stays up through the second commit cycle.
        drv_rs1 = 5'd10;
        issueOnly(5'd10);
        issueOnly(5'd10);
        startReq(REQ_LSU, 5'd10, 32'h1111_0001);
        applyStimulus();
        checkOutput("sb hazard after grant", 32'(hazard_rs1), 32'd1);
        startReq(REQ_LSU, 5'd10, 32'h1111_0002);
        applyStimulus();
        checkOutput("sb hazard after 1st commit", 32'(hazard_rs1), 32'd1);
        applyStimulus();
        checkOutput("sb hazard in 2nd commit cycle", 32'(last_haz1), 32'd1);
        checkOutput("sb hazard after 2nd commit", 32'(hazard_rs1), 32'd0);

        // Saturate x3, then free one slot with a commit.
        drv_rs1 = 5'd3;
        repeat (3) issueOnly(5'd3);
        issueOnly(5'd3);
        checkOutput("sat iss_ready blocked", 32'(last_iss_ready), 32'd0);
        checkOutput("sat cnt unchanged", 32'(iss_ready), 32'd0);
        startReq(REQ_ALU, 5'd3, 32'h0000_0333);
        applyStimulus();
        applyStimulus();
        checkOutput("sat iss_ready after commit", 32'(iss_ready), 32'd1);

        // Issue and commit to x9 in the same cycle, then an x0 write.
        drv_rs1 = 5'd9;
        issueOnly(5'd9);
        startReq(REQ_ALU, 5'd9, 32'h0000_0999);
        applyStimulus();
        drv_iss_valid = 1'b1;
        drv_iss_rd    = 5'd9;
        applyStimulus();
        checkOutput("simul hazard held", 32'(hazard_rs1), 32'd1);
        startReq(REQ_MUL, 5'd0, 32'hDEAD_BEEF);
        applyStimulus();
        checkOutput("x0 ready", 32'(last_ready), 32'b100);
        checkOutput("x0 RegWEn", 32'(RegWEn), 32'd0);

        // Randomized traffic with an asynchronous reset in the middle.
        for (int k = 0; k < 400; k++) begin
            if (k == 200) begin
                for (int i = 0; i < NR; i++)
                    if (!drv_valid[i]) startReq(i, 5'd0, $urandom);
                applyStimulus();
                @(negedge clk);
                #2;
                rst_n = 1'b0;
                #1;
                checkOutput("async RegWEn", 32'(RegWEn), 32'd0);
                checkOutput("async rd_addr", 32'(rd_addr), 32'd0);
                checkOutput("async rd_data", rd_data, 32'd0);
                checkOutput("async req_ready", 32'(bus.req_ready), 32'd0);
                for (int a = 1; a < 8; a++) begin
                    rs1_addr = 5'(a);
                    #1;
                    checkOutput($sformatf("async hazard x%0d", a), 32'(hazard_rs1), 32'd0);
                end
                modelReset();
                quietInputs();
                @(negedge clk);
                rst_n = 1'b1;
                for (int i = 0; i < NR; i++) startReq(i, 5'd0, $urandom);
                applyStimulus();
                checkOutput("post-reset grant", 32'(last_ready), 32'b001);
            end
            for (int i = 0; i < NR; i++) begin
                if (!drv_valid[i] && $urandom_range(0, 1) == 1) begin
                    r = pickOwed();
                    if (r < 0 || $urandom_range(0, 7) == 0) r = 0;
                    startReq(i, 5'(r), $urandom);
                end
            end
            drv_iss_valid = ($urandom_range(0, 9) < 6);
            drv_iss_rd    = 5'($urandom_range(0, 7));
            drv_rs1       = 5'($urandom_range(0, 7));
            drv_rs2       = 5'($urandom_range(0, 7));
            applyStimulus();
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
